// File: rtl/io_pkg.sv
// Shared types and constants for the output-side UART responder.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter one bit wider than the pointers.
// Rejects pushes when full and pops when empty; the head is readable combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // Full is decoded from the registered count, so a same-cycle pop never frees a slot early.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_out_uart.sv
// Output responder: buffers bytes issued by the core and serialises them as 8N1 on txd.
// Back-pressure to the core is the FIFO full flag.
module io_out_uart
    import io_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int CLK_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      out_issued,
    input  logic [31:0]               out_data,
    output logic                      out_stall,
    output logic                      txd,
    output logic                      tx_busy,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int BW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);
    localparam logic [IW-1:0] BIT_ONE   = IW'(1);

    uart_tx_state_t              state_q, state_d;
    logic [BW-1:0]               baud_q, baud_d;
    logic [IW-1:0]               bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        txd_q, txd_d;

    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [UART_DATA_BITS-1:0]   fifo_head;
    logic                        baud_done;
    logic                        unused_upper;

    assign unused_upper = ^out_data[31:UART_DATA_BITS];

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (out_issued),
        .wr_data (out_data[UART_DATA_BITS-1:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_stall = fifo_full;
    assign tx_busy   = (state_q != IDLE);
    assign txd       = txd_q;
    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // The line level is registered from the current state, trailing the state by one cycle.
    always_comb begin
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_io_out_uart.sv
// Randomised bench for io_out_uart: a queue-based FIFO/frame-timer model predicts every
// output each cycle, and a sampling receiver recovers bytes from txd for a scoreboard.
module tb_io_out_uart;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_issued;
    logic [31:0] out_data;
    logic        out_stall;
    logic        txd;
    logic        tx_busy;
    logic [2:0]  fifo_count;

    io_out_uart #(
        .DEPTH       (DEPTH),
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_issued (out_issued),
        .out_data   (out_data),
        .out_stall  (out_stall),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending bytes, remaining cycles of the current frame, frame byte.
    logic [7:0] m_fifo[$];
    logic [7:0] rx_exp[$];
    int         m_timer = 0;
    logic [7:0] m_frame = 8'h00;
    logic       m_txd   = 1'b1;
    int         pushed_total = 0;
    int         lost_total   = 0;
    int         rx_total     = 0;
    bit         saw_stall    = 1'b0;

    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rx_deliver();
        logic [7:0] exp;
        rx_total++;
        if (rx_exp.size() == 0) begin
            check("rx_unexpected_frame", 32'd1, 32'd0);
        end else begin
            exp = rx_exp.pop_front();
            check("rx_byte", {24'h0, rx_byte}, {24'h0, exp});
            $display("rx frame %0d: byte 0x%02h expected 0x%02h", rx_total, rx_byte, exp);
        end
    endtask

    task automatic tick();
        int         tprev;
        int         pos;
        bit         push_ok;
        logic [7:0] hd;
        @(posedge clk);
        if (rst) begin
            lost_total += m_fifo.size() + rx_exp.size();
            m_fifo.delete();
            rx_exp.delete();
            m_timer = 0;
            m_txd   = 1'b1;
        end else begin
            tprev = m_timer;
            if (tprev > 0) begin
                pos   = (FRAME - tprev) / CPB;
                m_txd = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : m_frame[pos-1];
            end else begin
                m_txd = 1'b1;
            end
            push_ok = out_issued && (m_fifo.size() < DEPTH);
            if (m_timer == 0 && m_fifo.size() > 0) begin
                hd      = m_fifo.pop_front();
                m_frame = hd;
                rx_exp.push_back(hd);
                m_timer = FRAME;
            end else if (m_timer > 0) begin
                m_timer--;
            end
            if (push_ok) begin
                m_fifo.push_back(out_data[7:0]);
                pushed_total++;
            end
        end
        #1;
        check("txd", {31'h0, txd}, {31'h0, m_txd});
        check("tx_busy", {31'h0, tx_busy}, {31'h0, (m_timer > 0)});
        check("out_stall", {31'h0, out_stall}, {31'h0, (m_fifo.size() == DEPTH)});
        check("fifo_count", {29'h0, fifo_count}, m_fifo.size());
        if (out_stall) saw_stall = 1'b1;
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (txd == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0) begin
                rx_byte[(rx_cnt - CPB/2) / CPB - 1] = txd;
            end else if (rx_cnt == 9*CPB + CPB/2) begin
                check("stop_bit", {31'h0, txd}, 32'd1);
                rx_deliver();
                rx_active = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [23:0] up);
        bit acc;
        int guard;
        guard      = 0;
        acc        = 1'b0;
        out_issued = 1'b1;
        out_data   = {up, b};
        while (!acc && guard < 2000) begin
            acc = (m_fifo.size() < DEPTH);
            tick();
            guard++;
        end
        if (!acc) check("send_timeout", 32'd1, 32'd0);
        out_issued = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_fifo.size() > 0 || m_timer > 0 || rx_active) && guard < 5000) begin
            tick();
            guard++;
        end
        if (guard >= 5000) check("drain_timeout", 32'd1, 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int guard;
        rst        = 1'b1;
        out_issued = 1'b0;
        out_data   = 32'h0;

        repeat (3) tick();
        check("reset_txd", {31'h0, txd}, 32'd1);
        check("reset_count", {29'h0, fifo_count}, 32'd0);
        check("reset_busy", {31'h0, tx_busy}, 32'd0);
        check("reset_stall", {31'h0, out_stall}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        send(8'hA5, 24'h000000);
        drain();

        send(8'h41, 24'hDEADBE);
        drain();

        saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(8'h10 + 8'(i * 17), 24'(32'($urandom)));
        end
        check("fill_stall_seen", {31'h0, saw_stall}, 32'd1);
        drain();

        send(8'h11, 24'h0);
        send(8'h22, 24'h0);
        send(8'h33, 24'h0);
        guard = 0;
        while (m_timer != FRAME - 17 && guard < 2000) begin
            tick();
            guard++;
        end
        check("rst_mid_reached", {31'h0, (m_timer == FRAME - 17)}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_txd", {31'h0, txd}, 32'd1);
        check("rst_mid_count", {29'h0, fifo_count}, 32'd0);
        check("rst_mid_busy", {31'h0, tx_busy}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        send(8'h3C, 24'h0);
        drain();

        for (int i = 0; i < 10; i++) begin
            send(8'($urandom), 24'(32'($urandom)));
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 24'(32'($urandom)));
            repeat ($urandom_range(0, 60)) tick();
        end
        drain();

        check("rx_total", rx_total, pushed_total - lost_total);
        check("rx_exp_empty", rx_exp.size(), 32'd0);
        check("final_count", {29'h0, fifo_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
